// File: rtl/prog_loader.sv
// prog_loader
//   Receives a byte stream, builds 16-bit instruction words (high byte
//   first), rejects encodings the instruction decoder cannot execute, and
//   writes legal words to the 32-word program memory. Holds the CPU while
//   a load runs and while an error is latched.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start, len          begin a load of len words (IDLE/DONE/ERROR only)
//   byte_in, byte_valid stream byte and its valid flag
//   byte_ready          loader accepts a byte this cycle (decoded from state)
//   pm_we/waddr/wdata   program memory write port
//   cpu_hold            keeps the CPU stalled
//   busy, done, err     status; done and err are sticky until next start
//   err_addr            offending word address (0 for a bad len)
//   word_cnt            words written in the current load
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, waiting for start
// HI    | waiting for the high byte of the next word
// LO    | waiting for the low byte; word is checked on arrival
// WRITE | one-cycle program memory write of the assembled word
// DONE  | load finished cleanly, CPU released
// ERROR | load aborted, CPU held until the next start
module prog_loader #(
    parameter int PM_DEPTH = 32,
    parameter int PM_AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       len,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             pm_we,
    output logic [PM_AW-1:0] pm_waddr,
    output logic [15:0]      pm_wdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [PM_AW-1:0] err_addr,
    output logic [5:0]       word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state, state_next;
    logic [7:0]         hi_q;
    logic [5:0]         len_q;
    logic [PM_AW-1:0]   addr;
    logic [15:0]        word_asm;
    logic               load;
    logic               take_hi;
    logic               take_lo;
    logic               bad_word;

    function automatic logic is_legal(input logic [3:0] op, input logic [3:0] rc);
        logic ok;
        ok = 1'b0;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7: ok = (rc <= 4'h4) || (rc >= 4'hC);
            // ST cannot target the immediate pseudo-register (rc=4)
            4'h6:       ok = (rc <= 4'h3) || (rc >= 4'hC);
            4'hA, 4'hF: ok = 1'b1;
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign word_asm   = {hi_q, byte_in};
    assign byte_ready = (state == S_HI) || (state == S_LO);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        take_hi    = 1'b0;
        take_lo    = 1'b0;
        bad_word   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    load = 1'b1;
                    if ((len == 6'd0) || (len > 6'(PM_DEPTH)))
                        state_next = S_ERROR;
                    else
                        state_next = S_HI;
                end
            end
            S_HI: begin
                if (byte_valid) begin
                    take_hi    = 1'b1;
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (byte_valid) begin
                    if (is_legal(word_asm[15:12], word_asm[11:8])) begin
                        take_lo    = 1'b1;
                        state_next = S_WRITE;
                    end else begin
                        bad_word   = 1'b1;
                        state_next = S_ERROR;
                    end
                end
            end
            S_WRITE: begin
                if (word_cnt + 6'd1 == len_q)
                    state_next = S_DONE;
                else
                    state_next = S_HI;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hi_q     <= '0;
            len_q    <= '0;
            addr     <= '0;
            pm_we    <= 1'b0;
            pm_waddr <= '0;
            pm_wdata <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
            word_cnt <= '0;
        end else begin
            state <= state_next;

            // Status outputs are registered copies of the next state so they
            // line up exactly with the state they describe.
            pm_we    <= take_lo;
            cpu_hold <= (state_next == S_HI) || (state_next == S_LO) ||
                        (state_next == S_WRITE) || (state_next == S_ERROR);
            busy     <= (state_next == S_HI) || (state_next == S_LO) ||
                        (state_next == S_WRITE);
            done     <= (state_next == S_DONE);
            err      <= (state_next == S_ERROR);

            if (load) begin
                len_q    <= len;
                addr     <= '0;
                word_cnt <= '0;
                err_addr <= '0;
            end

            if (take_hi)
                hi_q <= byte_in;

            if (take_lo) begin
                pm_waddr <= addr;
                pm_wdata <= word_asm;
            end

            if (bad_word)
                err_addr <= addr;

            if (state == S_WRITE) begin
                word_cnt <= word_cnt + 6'd1;
                if (state_next == S_HI)
                    addr <= addr + PM_AW'(1);
            end
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Loads program memory: receives a byte stream, assembles 16-bit instruction words (high byte first), checks each word against the instruction decoder's legal encodings, and writes it to the 32-word program memory.
- Holds the CPU (CPU_HOLD) while a load is in progress and while an error is latched.
- Sits between the external host/UART byte interface and program memory.
- Acts as the writer for the memory the decoder path reads.

Parameters:
- PM_DEPTH, 32, program memory depth in words; matches the 5-bit JMP address space.
- PM_AW, 5, program memory address width.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  begin a load; honoured only in IDLE, DONE or ERROR.
- LEN  in  6  number of words to load; sampled on an accepted START.
- BYTE_IN  in  8  stream byte.
- BYTE_VALID  in  1  BYTE_IN is valid.
- BYTE_READY  out  1  loader accepts a byte this cycle.
- PM_WE  out  1  program memory write strobe.
- PM_WADDR  out  5  program memory write address.
- PM_WDATA  out  16  instruction word to write.
- CPU_HOLD  out  1  keeps the CPU stalled or reset.
- BUSY  out  1  load in progress.
- DONE  out  1  load completed successfully; sticky.
- ERR  out  1  load aborted; sticky.
- ERR_ADDR  out  5  word address of the offending word, or 0 for a LEN error.
- WORD_CNT  out  6  words written in the current load.

Behaviour:
- Reset (async, RST_N=0):
  - State is IDLE.
  - All outputs are 0; PM_WE drops immediately.
  - A load interrupted by reset is abandoned; memory contents are not touched.
- All outputs are registered except BYTE_READY, which is decoded from state.
- Handshake: a byte transfers on a rising edge with BYTE_VALID=1 and BYTE_READY=1. BYTE_IN must be held stable while BYTE_VALID=1 and BYTE_READY=0.
- States:
  - IDLE: READY=0, HOLD=0. On START, sample LEN and clear DONE, ERR, ERR_ADDR, WORD_CNT and the address counter.
    - LEN==0 or LEN>PM_DEPTH -> ERROR with ERR_ADDR=0.
    - Otherwise -> HI.
  - HI: READY=1, HOLD=1, BUSY=1. On handshake, latch hi=BYTE_IN -> LO.
  - LO: READY=1, HOLD=1. On handshake, form word={hi,BYTE_IN} and check it.
    - Illegal -> ERROR with ERR_ADDR=current address; the word is not written.
    - Legal -> WRITE.
  - WRITE: READY=0. PM_WE=1 for exactly one cycle with PM_WADDR=addr and PM_WDATA=word; WORD_CNT increments.
    - If WORD_CNT+1==LEN -> DONE.
    - Otherwise addr+1 -> HI.
  - DONE: DONE=1, HOLD=0, BUSY=0. START restarts as in IDLE.
  - ERROR: ERR=1, HOLD=1, BUSY=0. START restarts as in IDLE; only START or reset releases HOLD.
- Legality check (op=word[15:12], rc=word[11:8]):
  - op must be one of 0..7, 0xA, 0xF; anything else is illegal.
  - For ops 0..5 and 7, rc must be in {0,1,2,3,4,C,D,E,F}.
  - For ST (op 6), rc must be in {0..3, C..F}; rc=4 (immediate destination) is illegal.
  - For NOP (0xA) and JMP (0xF), rc is ignored.
- Throughput: minimum 3 cycles per word (HI, LO, WRITE). The address never wraps, since LEN<=PM_DEPTH is guaranteed.
- Edge cases:
  - START while BUSY is ignored.
  - BYTE_VALID outside HI/LO is ignored; no byte is consumed.
  - START asserted in the same cycle as a handshake in HI/LO is ignored.
  - DONE and ERR are never both 1.

Test Plan:
- Start with LEN=3, stream 00 05 / 01 C0 / F0 10, no gaps -> PM_WE pulses at addr 0,1,2 with data 0x0005, 0x01C0, 0xF010; DONE=1, WORD_CNT=3, HOLD 1->0; first write lands 3 cycles after the first accepted byte.
- Backpressure and gaps: LEN=2 with BYTE_VALID toggled randomly -> bytes are consumed only when READY=1; writes 0x7312, 0xA000; no duplicate or lost bytes.
- Illegal opcode: LEN=4, second word 0x9000 -> ERR=1, ERR_ADDR=1, exactly 1 PM_WE seen, HOLD stays 1; a following START with LEN=1 and word 0x0000 -> DONE, ERR cleared.
- ST to immediate: word 0x6455 -> ERR at its address. Word 0x6C55 -> accepted. Word 0xF4F8 -> accepted (rc ignored for JMP).
- LEN=0 and LEN=33 -> ERR=1 with ERR_ADDR=0 the cycle after START, no writes. LEN=32 with legal words -> writes addr 0..31, DONE.
- Reset mid-load: drop RST_N while in WRITE -> PM_WE, BUSY, HOLD and all other outputs go to 0 asynchronously; after release, state is IDLE and a START mid-transfer is ignored until the loader is in DONE or ERROR.
